// File: rtl/mold_rereq_sched.sv
// MoldUDP64 retransmission-request scheduler: queues gaps and emits 3-beat request packets with retry.
module mold_rereq_sched #(
    parameter int unsigned        AXI_DATA_W  = 64,
    parameter int unsigned        AXI_KEEP_W  = 8,
    parameter int unsigned        SID_W       = 80,
    parameter int unsigned        SEQ_NUM_W   = 64,
    parameter int unsigned        ML_W        = 16,
    parameter int unsigned        FIFO_DEPTH  = 4,
    parameter logic [ML_W-1:0]    MAX_REQ_CNT = 16'd64,
    parameter int unsigned        RETRY_CYC   = 1024,
    parameter int unsigned        MAX_RETRY   = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           miss_seq_num_v_i,
    input  logic [SID_W-1:0]               miss_seq_num_sid_i,
    input  logic [SEQ_NUM_W-1:0]           miss_seq_num_start_i,
    input  logic [SEQ_NUM_W-1:0]           miss_seq_num_cnt_i,
    input  logic                           recv_v_i,
    input  logic [SID_W-1:0]               recv_sid_i,
    input  logic [SEQ_NUM_W-1:0]           recv_seq_num_i,
    output logic                           req_axis_tvalid_o,
    input  logic                           req_axis_tready_i,
    output logic [AXI_DATA_W-1:0]          req_axis_tdata_o,
    output logic [AXI_KEEP_W-1:0]          req_axis_tkeep_o,
    output logic                           req_axis_tlast_o,
    output logic [$clog2(FIFO_DEPTH):0]    pending_o,
    output logic                           overflow_o,
    output logic                           give_up_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(RETRY_CYC) + 1;
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);
    localparam int unsigned HDR_W = ML_W + SEQ_NUM_W + SID_W;

    typedef struct packed {
        logic [SID_W-1:0]     sid;
        logic [SEQ_NUM_W-1:0] start;
        logic [SEQ_NUM_W-1:0] stop;
    } entry_t;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    entry_t               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]     count_q;
    state_t               state_q, state_d;
    logic [1:0]           beat_q, beat_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [RTY_W-1:0]     retry_q, retry_d;
    logic                 tvalid_q, tvalid_d;
    logic [AXI_DATA_W-1:0] tdata_q, tdata_d;
    logic [AXI_KEEP_W-1:0] tkeep_q, tkeep_d;
    logic                 tlast_q, tlast_d;
    logic                 overflow_q, give_up_q, give_up_d;

    entry_t               head;
    logic [SEQ_NUM_W-1:0] head_len, req_end;
    logic [ML_W-1:0]      req_cnt;
    logic [HDR_W-1:0]     hdr;
    logic                 full, empty, push_req, push, pop, adv_head, fill;

    function automatic logic [AXI_DATA_W-1:0] beat_data(input logic [HDR_W-1:0] h, input logic [1:0] idx);
        case (idx)
            2'd0:    beat_data = h[AXI_DATA_W-1:0];
            2'd1:    beat_data = h[2*AXI_DATA_W-1:AXI_DATA_W];
            default: beat_data = AXI_DATA_W'(h[HDR_W-1:2*AXI_DATA_W]);
        endcase
    endfunction

    // Current chunk of the head entry and its request header
    always_comb begin
        head     = mem_q[rd_ptr_q];
        head_len = head.stop - head.start;
        req_cnt  = (head_len > SEQ_NUM_W'(MAX_REQ_CNT)) ? MAX_REQ_CNT : head_len[ML_W-1:0];
        req_end  = head.start + SEQ_NUM_W'(req_cnt);
        hdr      = {req_cnt, head.start, head.sid};
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        empty    = (count_q == '0);
        push_req = miss_seq_num_v_i && (miss_seq_num_cnt_i != '0);
        push     = push_req && (!full || pop);
        fill     = recv_v_i && (recv_sid_i == head.sid) && (recv_seq_num_i >= req_end);
    end

    // Next-state and packet output logic
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        tvalid_d  = tvalid_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tlast_d   = tlast_q;
        give_up_d = 1'b0;
        pop       = 1'b0;
        adv_head  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) state_d = SEND;
            end
            SEND: begin
                if (!tvalid_q) begin
                    tvalid_d = 1'b1;
                    beat_d   = 2'd0;
                    tdata_d  = beat_data(hdr, 2'd0);
                    tkeep_d  = '1;
                    tlast_d  = 1'b0;
                end else if (req_axis_tready_i) begin
                    if (beat_q == 2'd2) begin
                        tvalid_d = 1'b0;
                        tdata_d  = '0;
                        tkeep_d  = '0;
                        tlast_d  = 1'b0;
                        state_d  = WAIT;
                        timer_d  = '0;
                        retry_d  = retry_q + RTY_W'(1);
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        tdata_d = beat_data(hdr, beat_q + 2'd1);
                        tkeep_d = (beat_q == 2'd1) ? AXI_KEEP_W'(8'h0F) : '1;
                        tlast_d = (beat_q == 2'd1);
                    end
                end
            end
            WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                if (fill) begin
                    retry_d = '0;
                    state_d = IDLE;
                    if (req_end == head.stop) pop = 1'b1;
                    else                      adv_head = 1'b1;
                end else if (timer_q == TMR_W'(RETRY_CYC - 1)) begin
                    if (retry_q == RTY_W'(MAX_RETRY)) begin
                        give_up_d = 1'b1;
                        pop       = 1'b1;
                        retry_d   = '0;
                        state_d   = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, output and FIFO pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            give_up_q  <= 1'b0;
            overflow_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            give_up_q  <= give_up_d;
            overflow_q <= push_req && full && !pop;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    // Gap storage; head start advances when a non-final chunk is filled
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{sid:   miss_seq_num_sid_i,
                                 start: miss_seq_num_start_i,
                                 stop:  miss_seq_num_start_i + miss_seq_num_cnt_i};
        end
        if (adv_head) mem_q[rd_ptr_q].start <= req_end;
    end

    assign req_axis_tvalid_o = tvalid_q;
    assign req_axis_tdata_o  = tdata_q;
    assign req_axis_tkeep_o  = tkeep_q;
    assign req_axis_tlast_o  = tlast_q;
    assign pending_o         = count_q;
    assign overflow_o        = overflow_q;
    assign give_up_o         = give_up_q;

endmodule

// File: tb/tb_mold_rereq_sched.sv
// Directed testbench for mold_rereq_sched.
module tb_mold_rereq_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic         miss_v;
    logic [79:0]  miss_sid;
    logic [63:0]  miss_start, miss_cnt;
    logic         recv_v;
    logic [79:0]  recv_sid;
    logic [63:0]  recv_seq;
    logic         tvalid, tready, tlast;
    logic [63:0]  tdata;
    logic [7:0]   tkeep;
    logic [2:0]   pending;
    logic         overflow, give_up;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int pkt_cyc = 0;

    mold_rereq_sched dut (
        .clk                  (clk),
        .reset                (reset),
        .miss_seq_num_v_i     (miss_v),
        .miss_seq_num_sid_i   (miss_sid),
        .miss_seq_num_start_i (miss_start),
        .miss_seq_num_cnt_i   (miss_cnt),
        .recv_v_i             (recv_v),
        .recv_sid_i           (recv_sid),
        .recv_seq_num_i       (recv_seq),
        .req_axis_tvalid_o    (tvalid),
        .req_axis_tready_i    (tready),
        .req_axis_tdata_o     (tdata),
        .req_axis_tkeep_o     (tkeep),
        .req_axis_tlast_o     (tlast),
        .pending_o            (pending),
        .overflow_o           (overflow),
        .give_up_o            (give_up)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic miss(input logic [79:0] sid, input logic [63:0] start, input logic [63:0] cnt);
        miss_v = 1'b1; miss_sid = sid; miss_start = start; miss_cnt = cnt;
        tick();
        miss_v = 1'b0;
    endtask

    task automatic recv(input logic [79:0] sid, input logic [63:0] seq);
        recv_v = 1'b1; recv_sid = sid; recv_seq = seq;
        tick();
        recv_v = 1'b0;
    endtask

    // Waits for the next accepted beat; returns once the accepting edge has passed
    task automatic get_beat(output logic [63:0] d, output logic [7:0] k, output logic l,
                            output bit ok, input bit toggle);
        ok = 1'b0; d = '0; k = '0; l = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (toggle) tready = ~tready;
            if (tvalid && tready) begin
                d = tdata; k = tkeep; l = tlast; ok = 1'b1;
            end
            tick();
        end
    endtask

    task automatic check_pkt(input string tag, input logic [79:0] sid, input logic [63:0] seq,
                             input logic [15:0] cnt, input bit toggle);
        logic [159:0] h;
        logic [63:0]  d, exp_d;
        logic [7:0]   k;
        logic         l;
        bit           ok;
        h = {cnt, seq, sid};
        for (int b = 0; b < 3; b++) begin
            get_beat(d, k, l, ok, toggle);
            if (b == 0) pkt_cyc = cyc;
            exp_d = (b == 0) ? h[63:0] : (b == 1) ? h[127:64] : {32'h0, h[159:128]};
            chk($sformatf("%s b%0d seen", tag, b), 160'(ok), 160'(1));
            chk($sformatf("%s b%0d data", tag, b), 160'(d), 160'(exp_d));
            chk($sformatf("%s b%0d keep", tag, b), 160'(k), 160'((b == 2) ? 8'h0F : 8'hFF));
            chk($sformatf("%s b%0d last", tag, b), 160'(l), 160'(b == 2));
        end
    endtask

    initial begin
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        bit          ok;
        int          t1, t2, n;
        logic [63:0] b0;

        reset = 1'b1; miss_v = 1'b0; miss_sid = '0; miss_start = '0; miss_cnt = '0;
        recv_v = 1'b0; recv_sid = '0; recv_seq = '0; tready = 1'b1;
        tick(); tick();
        chk("rst tvalid", 160'(tvalid), 160'(0));
        chk("rst tdata", 160'(tdata), 160'(0));
        chk("rst pending", 160'(pending), 160'(0));
        chk("rst flags", 160'({overflow, give_up, tlast, tkeep}), 160'(0));
        reset = 1'b0;
        tick();

        // 1: basic 3-beat request
        miss(80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F0, 64'd3);
        chk("t1 pending", 160'(pending), 160'(1));
        get_beat(d, k, l, ok, 1'b0);
        chk("t1 b0 seen", 160'(ok), 160'(1));
        chk("t1 b0 data", 160'(d), 160'(64'h00000000DEADBEEF));
        chk("t1 b0 keep", 160'(k), 160'(8'hFF));
        chk("t1 b0 last", 160'(l), 160'(0));
        get_beat(d, k, l, ok, 1'b0);
        chk("t1 b1 data", 160'(d), 160'(64'hF0F0F0F0F0F00000));
        chk("t1 b1 keep", 160'(k), 160'(8'hFF));
        get_beat(d, k, l, ok, 1'b0);
        chk("t1 b2 data", 160'(d), 160'(64'h000000000003F0F0));
        chk("t1 b2 keep", 160'(k), 160'(8'h0F));
        chk("t1 b2 last", 160'(l), 160'(1));
        chk("t1 pending after", 160'(pending), 160'(1));

        // 2: foreign and short fills ignored, matching fill pops
        recv(80'hDEADBEEE, 64'hF0F0F0F0F0F0F0F3);
        recv(80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F2);
        chk("t2 ignored", 160'(pending), 160'(1));
        recv(80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F3);
        chk("t2 pop", 160'(pending), 160'(0));
        n = 0;
        for (int i = 0; i < 20; i++) begin if (tvalid) n++; tick(); end
        chk("t2 no packet", 160'(n), 160'(0));

        // 3: large gap split into chunks, across sequence wraparound
        miss(80'h1234, 64'hFFFFFFFFFFFFFFE0, 64'd100);
        check_pkt("t3 c0", 80'h1234, 64'hFFFFFFFFFFFFFFE0, 16'd64, 1'b0);
        recv(80'h1234, 64'h20);
        chk("t3 still queued", 160'(pending), 160'(1));
        check_pkt("t3 c1", 80'h1234, 64'h20, 16'd36, 1'b0);
        recv(80'h1234, 64'h44);
        chk("t3 pop", 160'(pending), 160'(0));

        // 4: no fill -> three sends, then give up
        miss(80'd77, 64'h5000, 64'd5);
        check_pkt("t4 p0", 80'd77, 64'h5000, 16'd5, 1'b0);
        t1 = pkt_cyc;
        check_pkt("t4 p1", 80'd77, 64'h5000, 16'd5, 1'b0);
        t2 = pkt_cyc;
        chk("t4 spacing1", 160'(t2 - t1), 160'(1028));
        check_pkt("t4 p2", 80'd77, 64'h5000, 16'd5, 1'b0);
        chk("t4 spacing2", 160'(pkt_cyc - t2), 160'(1028));
        n = 0; t1 = 0;
        for (int i = 0; i < 1100; i++) begin
            if (give_up) n++;
            if (tvalid) t1++;
            tick();
        end
        chk("t4 give_up once", 160'(n), 160'(1));
        chk("t4 no 4th packet", 160'(t1), 160'(0));
        chk("t4 pending", 160'(pending), 160'(0));

        // 4b: fill coinciding with final timeout wins
        miss(80'd88, 64'h6000, 64'd2);
        check_pkt("t4b p0", 80'd88, 64'h6000, 16'd2, 1'b0);
        check_pkt("t4b p1", 80'd88, 64'h6000, 16'd2, 1'b0);
        check_pkt("t4b p2", 80'd88, 64'h6000, 16'd2, 1'b0);
        n = 0;
        for (int i = 0; i < 1023; i++) begin if (give_up) n++; tick(); end
        recv(80'd88, 64'h6002);
        chk("t4b give_up", 160'(n + int'(give_up)), 160'(0));
        chk("t4b pending", 160'(pending), 160'(0));
        n = 0;
        for (int i = 0; i < 1100; i++) begin if (give_up || tvalid) n++; tick(); end
        chk("t4b quiet", 160'(n), 160'(0));

        // 5: overflow with tready low, zero-count ignored, push with pop accepted
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            miss_v = 1'b1; miss_sid = 80'd5; miss_start = 64'(i + 1) << 8; miss_cnt = 64'd2;
            tick();
        end
        miss_v = 1'b0;
        chk("t5 overflow", 160'(overflow), 160'(1));
        chk("t5 pending", 160'(pending), 160'(4));
        tick();
        chk("t5 overflow pulse", 160'(overflow), 160'(0));
        miss(80'd5, 64'h900, 64'd0);
        chk("t5 cnt0 no flag", 160'(overflow), 160'(0));
        chk("t5 cnt0 pending", 160'(pending), 160'(4));
        b0 = {8'd5};
        chk("t5 hold valid", 160'(tvalid), 160'(1));
        chk("t5 hold data", 160'(tdata), 160'(b0));
        for (int i = 0; i < 5; i++) tick();
        chk("t5 hold valid2", 160'(tvalid), 160'(1));
        chk("t5 hold data2", 160'(tdata), 160'(b0));
        tready = 1'b1;
        check_pkt("t5 p0", 80'd5, 64'h100, 16'd2, 1'b0);
        recv_v = 1'b1; recv_sid = 80'd5; recv_seq = 64'h102;
        miss_v = 1'b1; miss_sid = 80'd6; miss_start = 64'hA00; miss_cnt = 64'd3;
        tick();
        recv_v = 1'b0; miss_v = 1'b0;
        chk("t5 push+pop pending", 160'(pending), 160'(4));
        chk("t5 push+pop overflow", 160'(overflow), 160'(0));
        check_pkt("t5 p1", 80'd5, 64'h200, 16'd2, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0; tick();
        chk("t5 reset clears", 160'(pending), 160'(0));

        // 6: tready toggling, then reset mid-packet
        miss(80'd9, 64'h7000, 64'd4);
        check_pkt("t6 toggle", 80'd9, 64'h7000, 16'd4, 1'b1);
        tready = 1'b1;
        recv(80'd9, 64'h7004);
        chk("t6 pop", 160'(pending), 160'(0));
        miss(80'd9, 64'h8000, 64'd4);
        get_beat(d, k, l, ok, 1'b0);
        chk("t6 b0", 160'(d), 160'(64'd9));
        get_beat(d, k, l, ok, 1'b0);
        chk("t6 b1", 160'(d), 160'({48'h8000, 16'h0}));
        reset = 1'b1;
        tick();
        chk("t6 rst tvalid", 160'(tvalid), 160'(0));
        chk("t6 rst outputs", 160'({tdata, tkeep, tlast, pending, overflow, give_up}), 160'(0));
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin if (tvalid) n++; tick(); end
        chk("t6 aborted", 160'(n), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
